// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Every stage must hold a whole number of 4-bit lookahead groups.
    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (width > 0) && ((width % (CLA_GROUP * stages)) == 0);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit generate/propagate carry-lookahead group; cascaded to build one pipeline slice.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Flattened lookahead terms so no carry ripples through the group.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder with valid/ready flow control, one operand slice per stage.
// Optional signed Overflow output is enabled by defining CLA_OVERFLOW_EN.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int SLICE  = slice_w(WIDTH, STAGES);
    localparam int GROUPS = SLICE / CLA_GROUP;
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = (WIDTH'(1) << SLICE) - WIDTH'(1);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] c_p;
    logic [WIDTH-1:0]  a_p [STAGES];
    logic [WIDTH-1:0]  b_p [STAGES];
    logic [WIDTH-1:0]  s_p [STAGES];

    logic [STAGES-1:0] can_load;
    logic [STAGES-1:0] v_up;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];

    // A stage can load if out_ready is high or any stage at or below it is empty.
    always_comb begin
        logic room;
        room = out_ready;
        can_load = '0;
        for (int k = LAST; k >= 0; k--) begin
            room        = room | ~vld_p[k];
            can_load[k] = room;
        end
    end

    always_comb begin
        a_in[0] = A;
        b_in[0] = B;
        s_in[0] = '0;
        c_in[0] = Cin;
        v_up[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            s_in[k] = s_p[k-1];
            c_in[k] = c_p[k-1];
            v_up[k] = vld_p[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUPS:0]    gc;
        logic [SLICE-1:0]   sl;
        logic [WIDTH-1:0]   sl_ext;

        assign gc[0] = c_in[k];
        for (genvar g = 0; g < GROUPS; g++) begin : g_grp
            cla_group4 u_grp (
                .a  (a_in[k][k*SLICE + g*CLA_GROUP +: CLA_GROUP]),
                .b  (b_in[k][k*SLICE + g*CLA_GROUP +: CLA_GROUP]),
                .ci (gc[g]),
                .s  (sl[g*CLA_GROUP +: CLA_GROUP]),
                .co (gc[g+1])
            );
        end

        assign sl_ext   = WIDTH'(sl) << (k * SLICE);
        assign s_nxt[k] = (s_in[k] & ~(SLICE_MASK << (k * SLICE))) | sl_ext;
        assign c_nxt[k] = gc[GROUPS];
    end

    // Stage registers: operands skew forward, finished sum slices deskew alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            c_p   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_p[k] <= '0;
                b_p[k] <= '0;
                s_p[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (can_load[k]) begin
                    vld_p[k] <= v_up[k];
                    if (v_up[k]) begin
                        a_p[k] <= a_in[k];
                        b_p[k] <= b_in[k];
                        s_p[k] <= s_nxt[k];
                        c_p[k] <= c_nxt[k];
                    end
                end
            end
        end
    end

`ifdef CLA_OVERFLOW_EN
    logic ovf_p;

    // Signed overflow: operands share a sign that the result does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_p <= 1'b0;
        end else if (can_load[LAST] && v_up[LAST]) begin
            ovf_p <= (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                     (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
        end
    end

    assign Overflow = ovf_p;
`endif

    assign in_ready  = can_load[0];
    assign out_valid = vld_p[LAST];
    assign Sum       = s_p[LAST];
    assign Cout      = c_p[LAST];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised self-checking bench for pipelined_cla_adder against an arithmetic reference queue.
module tb_pipelined_cla_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Sum;
    logic        Cout;
    logic        Overflow_w;

    logic        iv16 = 1'b0;
    logic        ir16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ci16 = 1'b0;
    logic        ov16;
    logic        or16 = 1'b1;
    logic [15:0] s16;
    logic        co16;

    int   passed = 0;
    int   total  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout)
`ifdef CLA_OVERFLOW_EN
        , .Overflow(Overflow_w)
`endif
    );

`ifndef CLA_OVERFLOW_EN
    assign Overflow_w = 1'b0;
`endif

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .Cin(ci16), .out_valid(ov16), .out_ready(or16),
        .Sum(s16), .Cout(co16)
`ifdef CLA_OVERFLOW_EN
        , .Overflow()
`endif
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        exp_t e;
        logic [32:0] u;
        longint      sgn;
        u   = {1'b0, a} + {1'b0, b} + 33'(ci);
        sgn = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        e.sum  = u[31:0];
        e.cout = u[32];
        e.ovf  = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
        return e;
    endfunction

    // One clock cycle: drive on the falling edge, observe 1 time unit later, before the next rising edge.
    task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic ordy, output logic acc, output logic emit, output logic ov,
                       output logic [31:0] s, output logic co, output logic of);
        @(negedge clk);
        in_valid = iv; A = a; B = b; Cin = ci; out_ready = ordy;
        #1;
        acc  = iv && in_ready;
        ov   = out_valid;
        emit = out_valid && ordy;
        s    = Sum;
        co   = Cout;
        of   = Overflow_w;
        if (acc) q.push_back(model(a, b, ci));
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (Sum !== 32'h0) $display("FAIL reset_sum got=%h want=00000000", Sum); else passed++;
        total++; if (Cout !== 1'b0) $display("FAIL reset_cout got=%b want=0", Cout); else passed++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
    endtask

    task automatic test_latency();
        logic acc, emit, ov, co, of;
        logic [31:0] s;
        int   seen;
        exp_t e;
        cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc, emit, ov, s, co, of);
        total++; if (acc !== 1'b1) $display("FAIL latency_accept got=%b want=1", acc); else passed++;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, emit, ov, s, co, of);
            if (emit) begin
                seen++;
                total++; if (c != 4) $display("FAIL latency_cycles got=%0d want=4", c); else passed++;
                e = q.pop_front();
                total++;
                if (s !== 32'h0 || co !== 1'b1 || s !== e.sum || co !== e.cout)
                    $display("FAIL latency_result got=%h/%b want=00000000/1", s, co);
                else passed++;
            end
        end
        total++; if (seen != 1) $display("FAIL latency_count got=%0d want=1", seen); else passed++;
    endtask

    task automatic test_stream();
        logic acc, emit, ov, co, of;
        logic [31:0] s;
        int   sent, got, first, last;
        exp_t e;
        sent = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (sent < 8)
                cyc(1'b1, 32'(sent), 32'(sent) << 1, sent[0], 1'b1, acc, emit, ov, s, co, of);
            else
                cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, emit, ov, s, co, of);
            if (acc) sent++;
            if (emit) begin
                if (first < 0) first = c;
                last = c;
                e = q.pop_front();
                total++;
                if (s !== 32'(3*got + (got & 1)) || s !== e.sum || co !== e.cout)
                    $display("FAIL stream_beat%0d got=%h want=%h", got, s, 32'(3*got + (got & 1)));
                else passed++;
                got++;
            end
        end
        total++; if (got != 8) $display("FAIL stream_count got=%0d want=8", got); else passed++;
        total++; if (last - first != 7) $display("FAIL stream_bubbles span got=%0d want=7", last - first); else passed++;
    endtask

    task automatic test_stall();
        logic acc, emit, ov, co, of;
        logic [31:0] s, held;
        int   accepted, got;
        exp_t e;
        accepted = 0; held = '0;
        for (int c = 0; c < 9; c++) begin
            cyc(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, acc, emit, ov, s, co, of);
            if (acc) accepted++;
            if (c == 4) held = s;
            if (c > 4) begin
                total++;
                if (ov !== 1'b1 || s !== held) $display("FAIL stall_hold c=%0d got=%b/%h want=1/%h", c, ov, s, held);
                else passed++;
            end
        end
        total++; if (accepted != 4) $display("FAIL stall_accepted got=%0d want=4", accepted); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", in_ready); else passed++;
        got = 0;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, emit, ov, s, co, of);
            if (emit) begin
                e = q.pop_front();
                got++;
                total++;
                if (s !== e.sum || co !== e.cout) $display("FAIL stall_drain%0d got=%h/%b want=%h/%b", got, s, co, e.sum, e.cout);
                else passed++;
            end
        end
        total++; if (got != 4) $display("FAIL stall_drain_count got=%0d want=4", got); else passed++;
    endtask

    task automatic test_reset_mid();
        logic acc, emit, ov, co, of;
        logic [31:0] s;
        int   stale;
        for (int c = 0; c < 3; c++)
            cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, acc, emit, ov, s, co, of);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc, emit, ov, s, co, of);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc, emit, ov, s, co, of);
        total++; if (ov !== 1'b1) $display("FAIL rstmid_precond out_valid got=%b want=1", ov); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || Sum !== 32'h0 || Cout !== 1'b0)
            $display("FAIL rstmid_clear got=%b/%h/%b want=0/00000000/0", out_valid, Sum, Cout);
        else passed++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, emit, ov, s, co, of);
            if (emit) stale++;
        end
        total++; if (stale != 0) $display("FAIL rstmid_stale got=%0d want=0", stale); else passed++;
    endtask

    task automatic test_random();
        logic acc, emit, ov, co, of;
        logic [31:0] s, a, b;
        int   bad, got;
        exp_t e;
        bad = 0; got = 0;
        for (int c = 0; c < 400; c++) begin
            a = $urandom; b = $urandom;
            if (c % 50 == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            cyc((c < 360) ? 1'($urandom_range(0, 3) != 0) : 1'b0, a, b, 1'($urandom_range(0, 1)),
                (c < 360) ? 1'($urandom_range(0, 2) != 0) : 1'b1, acc, emit, ov, s, co, of);
            if (emit) begin
                got++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL random_extra got=%h", s);
                end else begin
                    e = q.pop_front();
                    if (s !== e.sum || co !== e.cout) begin
                        bad++;
                        $display("FAIL random_beat%0d got=%h/%b want=%h/%b", got, s, co, e.sum, e.cout);
                    end
                end
            end
        end
        total++; if (bad != 0) $display("FAIL random_results bad=%0d want=0", bad); else passed++;
        total++; if (q.size() != 0) $display("FAIL random_lost left=%0d want=0", q.size()); else passed++;
        total++; if (got < 100) $display("FAIL random_throughput got=%0d want>=100", got); else passed++;
    endtask

`ifdef CLA_OVERFLOW_EN
    task automatic test_overflow();
        logic acc, emit, ov, co, of;
        logic [31:0] s;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        int   got;
        exp_t e;
        ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h0000_0001;
        ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;
        ta[2] = 32'h1234_5678; tb[2] = 32'h0000_0001;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (c < 3) cyc(1'b1, ta[c], tb[c], 1'b0, 1'b1, acc, emit, ov, s, co, of);
            else       cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, emit, ov, s, co, of);
            if (emit) begin
                e = q.pop_front();
                total++;
                if (s !== e.sum || co !== e.cout || of !== e.ovf)
                    $display("FAIL overflow_case%0d got=%h/%b/%b want=%h/%b/%b", got, s, co, of, e.sum, e.cout, e.ovf);
                else passed++;
                got++;
            end
        end
        total++; if (got != 3) $display("FAIL overflow_count got=%0d want=3", got); else passed++;
    endtask
`endif

    task automatic test_w16();
        logic [16:0] u;
        logic [15:0] ea [4];
        logic [15:0] eb [4];
        logic        ec [4];
        int          at;
        ea[0] = 16'h00FF; eb[0] = 16'h0001; ec[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            ea[i] = 16'($urandom); eb[i] = 16'($urandom); ec[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv16 = 1'b1; a16 = ea[i]; b16 = eb[i]; ci16 = ec[i]; or16 = 1'b1;
            u = {1'b0, ea[i]} + {1'b0, eb[i]} + 17'(ec[i]);
            at = -1;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                iv16 = 1'b0;
                #1;
                if (ov16 && at < 0) begin
                    at = c;
                    total++;
                    if (s16 !== u[15:0] || co16 !== u[16])
                        $display("FAIL w16_beat%0d got=%h/%b want=%h/%b", i, s16, co16, u[15:0], u[16]);
                    else passed++;
                end
            end
            total++; if (at != 2) $display("FAIL w16_latency%0d got=%0d want=2", i, at); else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef CLA_OVERFLOW_EN
        test_overflow();
`endif
        test_w16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
